// File: rtl/booth_pp_accum.sv
// Sequential radix-4 Booth partial-product accumulator: one Booth group per clock into a 2*WIDTH sum.
// Optional BOOTH_EARLY_TERM_EN: finish as soon as every remaining group has zero magnitude.
module booth_pp_accum #(
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          mcand,
  input  logic [3*(WIDTH/2)-1:0]    code,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*WIDTH-1:0]        product,
  output logic                      busy
);

  localparam int GROUPS = WIDTH / 2;
  localparam int PW     = 2 * WIDTH;
  localparam int IW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                  state;
  logic [WIDTH-1:0]        mcand_q;
  logic [3*GROUPS-1:0]     code_q;
  logic [PW-1:0]           acc;
  logic [IW-1:0]           idx;

  logic [2:0]              grp;
  logic [PW-1:0]           a_ext;
  logic [PW-1:0]           mag;
  logic [PW-1:0]           pp;
  logic [PW-1:0]           acc_next;
  logic                    last;
  logic                    stop;

  // Current group's partial product; x2 wins over x1 so illegal codes are simply tolerated.
  always_comb begin
    grp      = code_q[3*idx +: 3];
    a_ext    = {{WIDTH{mcand_q[WIDTH-1]}}, mcand_q};
    mag      = grp[1] ? (a_ext << 1) : (grp[0] ? a_ext : '0);
    pp       = grp[2] ? (-mag) : mag;
    acc_next = acc + (pp << (2*idx));
    last     = (idx == IW'(GROUPS-1));
  end

`ifdef BOOTH_EARLY_TERM_EN
  logic [GROUPS-1:0] live;
  logic [GROUPS-1:0] rest_zero;

  // rest_zero[g]: no group above g has a nonzero magnitude (neg alone adds nothing).
  for (genvar gi = 0; gi < GROUPS; gi++) begin : g_rest
    assign live[gi] = code_q[3*gi+1] | code_q[3*gi];
    if (gi == GROUPS-1) begin : g_top
      assign rest_zero[gi] = 1'b1;
    end else begin : g_mid
      assign rest_zero[gi] = ~|live[GROUPS-1:gi+1];
    end
  end

  assign stop = last | rest_zero[idx];
`else
  assign stop = last;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mcand_q   <= '0;
      code_q    <= '0;
      acc       <= '0;
      idx       <= '0;
      product   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand_q  <= mcand;
            code_q   <= code;
            acc      <= '0;
            idx      <= '0;
            state    <= CALC;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        CALC: begin
          acc <= acc_next;
          idx <= idx + 1'b1;
          if (stop) begin
            state     <= DONE;
            product   <= acc_next;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          // New operands wait here until the result has been taken.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_pp_accum.sv
// Self-checking bench for booth_pp_accum (WIDTH = 8): vector table, random ops against a
// Booth-digit arithmetic model, plus backpressure and mid-operation reset sequences.
module tb_booth_pp_accum;

  localparam int WIDTH  = 8;
  localparam int GROUPS = WIDTH / 2;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  mcand;
  logic [11:0] code;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;

  booth_pp_accum #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mcand     (mcand),
    .code      (code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [11:0] c;
    logic [15:0] exp_p;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Multiplier value = sum of Booth digits * 4^g; product = A * multiplier mod 2^16.
  function automatic logic [15:0] model(input logic [7:0] a, input logic [11:0] c);
    int m;
    int d;
    int p;
    m = 0;
    for (int g = 0; g < GROUPS; g++) begin
      d = c[3*g+1] ? 2 : (c[3*g] ? 1 : 0);
      if (c[3*g+2]) d = -d;
      m += d * (4 ** g);
    end
    p = $signed(a) * m;
    return p[15:0];
  endfunction

  // CALC edges between accept and out_valid.
  function automatic int exp_lat(input logic [11:0] c);
`ifdef BOOTH_EARLY_TERM_EN
    int k;
    k = 1;
    for (int g = 0; g < GROUPS; g++)
      if (c[3*g+1] || c[3*g]) k = g + 1;
    return k;
`else
    return GROUPS;
`endif
  endfunction

  // Entered and left at a negedge with out_ready = 1.
  task automatic run_op(input logic [7:0] a, input logic [11:0] c,
                        output logic [15:0] p, output int lat);
    int guard;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("in_ready_wait", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    mcand    = a;
    code     = c;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    p = product;
    @(posedge clk);
    @(negedge clk);
  endtask

  vec_t        vecs[6];
  logic [15:0] p;
  int          lat;
  int          cnt;
  logic [7:0]  ra;
  logic [11:0] rc;

  initial begin
    vecs[0] = '{8'h03, 12'h009, 16'h000F};
    vecs[1] = '{8'h80, 12'hC00, 16'h4000};
    vecs[2] = '{8'h7F, 12'h925, 16'hFF81};
    vecs[3] = '{8'h55, 12'h000, 16'h0000};
    vecs[4] = '{8'h01, 12'h003, 16'h0002};
    vecs[5] = '{8'hFF, 12'h009, 16'hFFFB};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    mcand     = '0;
    code      = '0;
    #1;
    check("rst_product",   {16'd0, product}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy",      {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].c, p, lat);
      $display("vec %0d: a=%02h code=%03h product=%04h latency=%0d", i, vecs[i].a, vecs[i].c, p, lat);
      check($sformatf("vec%0d_product", i), {16'd0, p}, {16'd0, vecs[i].exp_p});
      check($sformatf("vec%0d_latency", i), lat, exp_lat(vecs[i].c));
    end

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rc = 12'($urandom);
      if (i % 4 == 0) rc[11:6] = '0;
      run_op(ra, rc, p, lat);
      $display("rnd %0d: a=%02h code=%03h product=%04h latency=%0d", i, ra, rc, p, lat);
      check($sformatf("rnd%0d_product", i), {16'd0, p}, {16'd0, model(ra, rc)});
      check($sformatf("rnd%0d_latency", i), lat, exp_lat(rc));
    end

    // Backpressure: result held, new pair presented early but accepted only after handshake.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    mcand     = 8'h03;
    code      = 12'h009;
    @(posedge clk);
    @(negedge clk);
    mcand = 8'h7F;
    code  = 12'h925;
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 20) begin
      check("bp_calc_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      cnt++;
    end
    check("bp_out_valid_rise", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_product", {16'd0, product}, 32'h000F);
      check("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_hold_out_valid", {31'd0, out_valid}, 32'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    $display("bp: handshake done, product=%04h in_ready=%0b", product, in_ready);
    check("bp_idle_out_valid", {31'd0, out_valid}, 32'd0);
    check("bp_idle_in_ready", {31'd0, in_ready}, 32'd1);
    check("bp_idle_product_held", {16'd0, product}, 32'h000F);
    @(negedge clk);
    check("bp_accepted", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    $display("bp: second op product=%04h", product);
    check("bp_second_product", {16'd0, product}, 32'hFF81);
    @(negedge clk);

    // Reset asserted asynchronously during the second CALC cycle.
    in_valid = 1'b1;
    mcand    = 8'h03;
    code     = 12'h009;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_product", {16'd0, product}, 32'd0);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) cnt++;
    end
    check("post_rst_no_output", cnt, 0);
    run_op(8'hFF, 12'h009, p, lat);
    $display("post-reset op: a=ff code=009 product=%04h latency=%0d", p, lat);
    check("post_rst_product", {16'd0, p}, 32'hFFFB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
